// File: rtl/fp_rf_pkg.sv
// Shared constants and port-slicing helpers for the FP register file and its scoreboard.
package fp_rf_pkg;

  localparam int FP_DATA_W = 32;
  localparam int FP_NREG   = 32;
  localparam int FP_NRD    = 3;
  localparam int FP_NWR    = 2;

  // Lowest bit of port `port` inside a flattened bus of `width`-bit lanes.
  function automatic int slice_lo(input int port, input int width);
    return port * width;
  endfunction

endpackage

// File: rtl/fp_scoreboard.sv
// Busy scoreboard: one bit per FP register, set on issue, cleared by writeback or flush.
module fp_scoreboard
  import fp_rf_pkg::*;
#(
  parameter int NREG      = FP_NREG,
  parameter int NWR       = FP_NWR,
  parameter int HARD_ZERO = 1,
  localparam int AW       = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NWR-1:0]    wr_en,
  input  logic [NWR*AW-1:0] wr_addr,
  input  logic              alloc_en,
  input  logic [AW-1:0]     alloc_addr,
  input  logic              flush,
  output logic [NREG-1:0]   busy_vec,
  output logic              alloc_err
);

  logic [NREG-1:0] busy_reg, busy_next;
  logic [NREG-1:0] clr_vec, set_vec;
  logic            alloc_err_reg, alloc_err_next;

  always_comb begin
    clr_vec = '0;
    for (int i = 0; i < NWR; i++) begin
      if (wr_en[i]) clr_vec[wr_addr[slice_lo(i, AW) +: AW]] = 1'b1;
    end
  end

  always_comb begin
    set_vec = '0;
    if (alloc_en && !(HARD_ZERO != 0 && alloc_addr == '0)) set_vec[alloc_addr] = 1'b1;
  end

  // A new allocation wins over both writeback clears and flush.
  always_comb begin
    busy_next      = (flush ? '0 : (busy_reg & ~clr_vec)) | set_vec;
    alloc_err_next = alloc_err_reg | ((|(set_vec & busy_reg & ~clr_vec)) & ~flush);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_reg      <= '0;
      alloc_err_reg <= 1'b0;
    end else begin
      busy_reg      <= busy_next;
      alloc_err_reg <= alloc_err_next;
    end
  end

  assign busy_vec  = busy_reg;
  assign alloc_err = alloc_err_reg;

endmodule

// File: rtl/fp_regfile_sb.sv
// Multi-port FP register file with same-cycle write forwarding and an issue scoreboard.
module fp_regfile_sb
  import fp_rf_pkg::*;
#(
  parameter int DATA_W    = FP_DATA_W,
  parameter int NREG      = FP_NREG,
  parameter int NRD       = FP_NRD,
  parameter int NWR       = FP_NWR,
  parameter int HARD_ZERO = 1,
  parameter int BYPASS    = 1,
  localparam int AW       = $clog2(NREG)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NRD*AW-1:0]     rd_addr,
  output logic [NRD*DATA_W-1:0] rd_data,
  output logic [NRD-1:0]        rd_busy,
  input  logic [NWR-1:0]        wr_en,
  input  logic [NWR*AW-1:0]     wr_addr,
  input  logic [NWR*DATA_W-1:0] wr_data,
  input  logic                  alloc_en,
  input  logic [AW-1:0]         alloc_addr,
  input  logic                  flush,
  output logic [NREG-1:0]       busy_vec,
  output logic                  alloc_err
);

  logic [DATA_W-1:0] mem_reg [NREG];
  logic [NWR-1:0]    wr_keep;

  genvar gi;
  generate
    for (gi = 0; gi < NWR; gi++) begin : g_wr_keep
      assign wr_keep[gi] = wr_en[gi] &&
                           !(HARD_ZERO != 0 && wr_addr[slice_lo(gi, AW) +: AW] == '0);
    end
  endgenerate

  // Ports are applied in ascending order so the highest index wins a collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) mem_reg[r] <= '0;
    end else begin
      for (int i = 0; i < NWR; i++) begin
        if (wr_keep[i])
          mem_reg[wr_addr[slice_lo(i, AW) +: AW]] <= wr_data[slice_lo(i, DATA_W) +: DATA_W];
      end
    end
  end

  generate
    for (gi = 0; gi < NRD; gi++) begin : g_rd
      logic [AW-1:0]     ra;
      logic [DATA_W-1:0] rd_val;
      logic              rd_fwd;

      assign ra = rd_addr[slice_lo(gi, AW) +: AW];

      always_comb begin
        rd_val = mem_reg[ra];
        rd_fwd = 1'b0;
        if (BYPASS != 0) begin
          for (int i = 0; i < NWR; i++) begin
            if (wr_keep[i] && wr_addr[slice_lo(i, AW) +: AW] == ra) begin
              rd_val = wr_data[slice_lo(i, DATA_W) +: DATA_W];
              rd_fwd = 1'b1;
            end
          end
        end
        if (HARD_ZERO != 0 && ra == '0) rd_val = '0;
      end

      // A forwarded operand is already available, so it is not reported busy.
      assign rd_data[slice_lo(gi, DATA_W) +: DATA_W] = rd_val;
      assign rd_busy[gi] = busy_vec[ra] & ~rd_fwd;
    end
  endgenerate

  fp_scoreboard #(
    .NREG      (NREG),
    .NWR       (NWR),
    .HARD_ZERO (HARD_ZERO)
  ) u_sb (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .alloc_en   (alloc_en),
    .alloc_addr (alloc_addr),
    .flush      (flush),
    .busy_vec   (busy_vec),
    .alloc_err  (alloc_err)
  );

endmodule

// File: tb/tb_fp_regfile_sb.sv
// Two configurations (bypass/3R2W/32 regs and no-bypass/2R1W/16 regs) driven in lockstep against a reference model.
module tb_fp_regfile_sb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, alloc_en, flush;
  // configuration A
  logic [14:0] rd_addr_a;
  logic [95:0] rd_data_a;
  logic [2:0]  rd_busy_a;
  logic [1:0]  wr_en_a;
  logic [9:0]  wr_addr_a;
  logic [63:0] wr_data_a;
  logic [4:0]  alloc_addr_a;
  logic [31:0] busy_vec_a;
  logic        alloc_err_a;
  // configuration B
  logic [7:0]  rd_addr_b;
  logic [63:0] rd_data_b;
  logic [1:0]  rd_busy_b;
  logic [0:0]  wr_en_b;
  logic [3:0]  wr_addr_b;
  logic [31:0] wr_data_b;
  logic [3:0]  alloc_addr_b;
  logic [15:0] busy_vec_b;
  logic        alloc_err_b;

  fp_regfile_sb #(.DATA_W(32), .NREG(32), .NRD(3), .NWR(2), .HARD_ZERO(1), .BYPASS(1)) u_dut_a (
    .clk(clk), .rst(rst), .rd_addr(rd_addr_a), .rd_data(rd_data_a), .rd_busy(rd_busy_a),
    .wr_en(wr_en_a), .wr_addr(wr_addr_a), .wr_data(wr_data_a), .alloc_en(alloc_en),
    .alloc_addr(alloc_addr_a), .flush(flush), .busy_vec(busy_vec_a), .alloc_err(alloc_err_a)
  );

  fp_regfile_sb #(.DATA_W(32), .NREG(16), .NRD(2), .NWR(1), .HARD_ZERO(1), .BYPASS(0)) u_dut_b (
    .clk(clk), .rst(rst), .rd_addr(rd_addr_b), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
    .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b), .alloc_en(alloc_en),
    .alloc_addr(alloc_addr_b), .flush(flush), .busy_vec(busy_vec_b), .alloc_err(alloc_err_b)
  );

  // Abstract stimulus; B uses only write lane 1 and the low 4 address bits.
  int unsigned s_ra[3];
  bit          s_we[2];
  int unsigned s_wa[2];
  logic [31:0] s_wd[2];
  bit          s_ae, s_fl, s_rst;
  int unsigned s_aa;

  logic [31:0] m_mem[2][32];
  bit          m_busy[2][32];
  bit          m_err[2];

  int tests = 0;
  int fails = 0;

  function automatic int nreg(input int c);
    return (c == 0) ? 32 : 16;
  endfunction

  function automatic int nrd(input int c);
    return (c == 0) ? 3 : 2;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wport(input int c, input int i, output bit en, output int unsigned a,
                       output logic [31:0] d);
    if (c == 0) begin
      en = s_we[i]; a = s_wa[i] % 32; d = s_wd[i];
    end else if (i == 1) begin
      en = s_we[1]; a = s_wa[1] % 16; d = s_wd[1];
    end else begin
      en = 1'b0; a = 0; d = '0;
    end
  endtask

  task automatic apply();
    rst          = s_rst;
    alloc_en     = s_ae;
    flush        = s_fl;
    alloc_addr_a = 5'(s_aa % 32);
    alloc_addr_b = 4'(s_aa % 16);
    for (int k = 0; k < 3; k++) rd_addr_a[k*5 +: 5] = 5'(s_ra[k] % 32);
    for (int k = 0; k < 2; k++) rd_addr_b[k*4 +: 4] = 4'(s_ra[k] % 16);
    for (int i = 0; i < 2; i++) begin
      wr_en_a[i]            = s_we[i];
      wr_addr_a[i*5 +: 5]   = 5'(s_wa[i] % 32);
      wr_data_a[i*32 +: 32] = s_wd[i];
    end
    wr_en_b[0] = s_we[1];
    wr_addr_b  = 4'(s_wa[1] % 16);
    wr_data_b  = s_wd[1];
  endtask

  // Expected combinational read: stored value, overridden by the last same-cycle writer when bypassing.
  task automatic exp_read(input int c, input int k, output logic [31:0] d, output bit b);
    int unsigned a, wa;
    bit en;
    logic [31:0] wd;
    a = s_ra[k] % nreg(c);
    d = m_mem[c][a];
    b = m_busy[c][a];
    if (c == 0) begin
      for (int i = 0; i < 2; i++) begin
        wport(c, i, en, wa, wd);
        if (en && wa == a && a != 0) begin
          d = wd;
          b = 1'b0;
        end
      end
    end
    if (a == 0) d = '0;
  endtask

  task automatic model_edge();
    bit clr[32];
    bit en;
    int unsigned a, aa;
    logic [31:0] d;
    for (int c = 0; c < 2; c++) begin
      if (s_rst) begin
        for (int r = 0; r < 32; r++) begin
          m_mem[c][r]  = '0;
          m_busy[c][r] = 1'b0;
        end
        m_err[c] = 1'b0;
      end else begin
        for (int r = 0; r < 32; r++) clr[r] = 1'b0;
        for (int i = 0; i < 2; i++) begin
          wport(c, i, en, a, d);
          if (en) clr[a] = 1'b1;
        end
        aa = s_aa % nreg(c);
        if (s_ae && aa != 0 && m_busy[c][aa] && !clr[aa] && !s_fl) m_err[c] = 1'b1;
        for (int i = 0; i < 2; i++) begin
          wport(c, i, en, a, d);
          if (en && a != 0) m_mem[c][a] = d;
        end
        for (int r = 0; r < nreg(c); r++) if (s_fl || clr[r]) m_busy[c][r] = 1'b0;
        if (s_ae && aa != 0) m_busy[c][aa] = 1'b1;
      end
    end
  endtask

  task automatic compare_model();
    logic [31:0] ed, ev, act;
    bit eb;
    string cn;
    for (int c = 0; c < 2; c++) begin
      cn = (c == 0) ? "A" : "B";
      for (int k = 0; k < nrd(c); k++) begin
        exp_read(c, k, ed, eb);
        act = (c == 0) ? rd_data_a[k*32 +: 32] : rd_data_b[(k%2)*32 +: 32];
        check($sformatf("%s.rd_data%0d", cn, k), act, ed);
        act = {31'b0, (c == 0) ? rd_busy_a[k] : rd_busy_b[k%2]};
        check($sformatf("%s.rd_busy%0d", cn, k), act, {31'b0, eb});
      end
      ev = '0;
      for (int r = 0; r < nreg(c); r++) ev[r] = m_busy[c][r];
      act = (c == 0) ? busy_vec_a : {16'h0, busy_vec_b};
      check($sformatf("%s.busy_vec", cn), act, ev);
      act = {31'b0, (c == 0) ? alloc_err_a : alloc_err_b};
      check($sformatf("%s.alloc_err", cn), act, {31'b0, m_err[c]});
    end
  endtask

  task automatic idle();
    for (int k = 0; k < 3; k++) s_ra[k] = 0;
    for (int i = 0; i < 2; i++) begin
      s_we[i] = 1'b0; s_wa[i] = 0; s_wd[i] = '0;
    end
    s_ae = 1'b0; s_aa = 0; s_fl = 1'b0; s_rst = 1'b0;
  endtask

  task automatic drive(input string what);
    apply();
    #1;
    compare_model();
    if (what != "") $display("[TB] %s", what);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  function automatic int unsigned pick_addr();
    return ($urandom_range(0, 1) == 0) ? $urandom_range(0, 7) : $urandom_range(0, 31);
  endfunction

  initial begin
    idle();
    s_rst = 1'b1;
    apply();
    tick();
    s_rst = 1'b0;

    // reset clears data and scoreboard, even with a same-cycle alloc
    idle(); s_we[1] = 1'b1; s_wa[1] = 5; s_wd[1] = 32'h3F800000;
    drive("write f5=3f800000"); tick();
    idle(); s_ra[0] = 5;
    drive("read f5");
    check("A.f5_written", rd_data_a[31:0], 32'h3F800000);
    check("B.f5_written", rd_data_b[31:0], 32'h3F800000);
    tick();
    idle(); s_rst = 1'b1; s_ae = 1'b1; s_aa = 5;
    drive("reset with alloc f5"); tick();
    idle(); s_ra[0] = 5;
    drive("read f5 after reset");
    check("A.f5_reset", rd_data_a[31:0], 32'h0);
    check("B.f5_reset", rd_data_b[31:0], 32'h0);
    check("A.busy_reset", busy_vec_a, 32'h0);
    tick();

    // write collision on f3
    idle(); s_we[0] = 1'b1; s_wa[0] = 3; s_wd[0] = 32'h11111111;
    s_we[1] = 1'b1; s_wa[1] = 3; s_wd[1] = 32'h22222222; s_ra[0] = 3;
    drive("collision f3");
    check("A.coll_bypass", rd_data_a[31:0], 32'h22222222);
    check("B.coll_old", rd_data_b[31:0], 32'h0);
    tick();
    idle(); s_ra[0] = 3;
    drive("read f3");
    check("A.coll_stored", rd_data_a[31:0], 32'h22222222);
    check("B.coll_stored", rd_data_b[31:0], 32'h22222222);
    tick();

    // hard zero register
    idle(); s_we[1] = 1'b1; s_wa[1] = 0; s_wd[1] = 32'hDEADBEEF; s_ae = 1'b1; s_aa = 0;
    drive("write+alloc f0");
    check("A.f0_same", rd_data_a[31:0], 32'h0);
    tick();
    idle();
    drive("read f0");
    check("A.f0_data", rd_data_a[31:0], 32'h0);
    check("A.f0_busy", {31'b0, busy_vec_a[0]}, 32'h0);
    check("B.f0_busy", {31'b0, busy_vec_b[0]}, 32'h0);
    tick();

    // scoreboard sequence on f7
    idle(); s_ae = 1'b1; s_aa = 7;
    drive("alloc f7"); tick();
    idle(); s_ra[0] = 7;
    drive("probe f7");
    check("A.f7_busy", {31'b0, busy_vec_a[7]}, 32'h1);
    check("A.f7_rd_busy", {31'b0, rd_busy_a[0]}, 32'h1);
    check("B.f7_rd_busy", {31'b0, rd_busy_b[0]}, 32'h1);
    tick();
    idle(); s_ae = 1'b1; s_aa = 7; s_we[1] = 1'b1; s_wa[1] = 7; s_wd[1] = 32'h40490FDB;
    drive("write+alloc f7"); tick();
    idle(); s_ra[0] = 7;
    drive("probe f7");
    check("A.f7_still_busy", {31'b0, busy_vec_a[7]}, 32'h1);
    tick();
    idle(); s_we[1] = 1'b1; s_wa[1] = 7; s_wd[1] = 32'h40490FDB; s_ra[0] = 7;
    drive("write f7");
    check("A.f7_fwd_busy", {31'b0, rd_busy_a[0]}, 32'h0);
    check("A.f7_fwd_data", rd_data_a[31:0], 32'h40490FDB);
    check("B.f7_nofwd_busy", {31'b0, rd_busy_b[0]}, 32'h1);
    tick();
    idle(); s_ra[0] = 7;
    drive("probe f7");
    check("A.f7_cleared", {31'b0, busy_vec_a[7]}, 32'h0);
    check("B.f7_cleared", {31'b0, busy_vec_b[7]}, 32'h0);
    tick();

    // double allocation is sticky until reset
    idle(); s_ae = 1'b1; s_aa = 9;
    drive("alloc f9"); tick();
    drive("alloc f9 again"); tick();
    idle();
    drive("probe err");
    check("A.err_set", {31'b0, alloc_err_a}, 32'h1);
    check("B.err_set", {31'b0, alloc_err_b}, 32'h1);
    tick();
    idle(); s_we[1] = 1'b1; s_wa[1] = 9; s_wd[1] = 32'h1;
    drive("write f9"); tick();
    idle();
    drive("probe err");
    check("A.err_sticky", {31'b0, alloc_err_a}, 32'h1);
    tick();
    idle(); s_rst = 1'b1;
    drive("reset"); tick();
    idle();
    drive("probe err");
    check("A.err_reset", {31'b0, alloc_err_a}, 32'h0);
    tick();

    // flush with simultaneous alloc
    idle(); s_we[1] = 1'b1; s_ae = 1'b1;
    s_wa[1] = 1; s_aa = 1; s_wd[1] = 32'h00000011; drive("write+alloc f1"); tick();
    s_wa[1] = 2; s_aa = 2; s_wd[1] = 32'h00000022; drive("write+alloc f2"); tick();
    s_wa[1] = 4; s_aa = 4; s_wd[1] = 32'h00000044; drive("write+alloc f4"); tick();
    idle();
    drive("probe busy");
    check("A.busy_pre_flush", busy_vec_a, 32'h16);
    tick();
    idle(); s_fl = 1'b1; s_ae = 1'b1; s_aa = 6;
    drive("flush+alloc f6"); tick();
    idle(); s_ra[0] = 1; s_ra[1] = 2; s_ra[2] = 4;
    drive("probe after flush");
    check("A.busy_flush", busy_vec_a, 32'h40);
    check("B.busy_flush", {16'h0, busy_vec_b}, 32'h40);
    check("A.f1_kept", rd_data_a[31:0], 32'h11);
    check("A.f2_kept", rd_data_a[63:32], 32'h22);
    check("A.f4_kept", rd_data_a[95:64], 32'h44);
    check("B.f2_kept", rd_data_b[63:32], 32'h22);
    tick();

    // randomized traffic against the model
    for (int n = 0; n < 1500; n++) begin
      s_rst = ($urandom_range(0, 99) == 0);
      s_fl  = ($urandom_range(0, 15) == 0);
      s_ae  = ($urandom_range(0, 2) == 0);
      s_aa  = pick_addr();
      for (int i = 0; i < 2; i++) begin
        s_we[i] = $urandom_range(0, 1);
        s_wa[i] = pick_addr();
        s_wd[i] = $urandom;
      end
      for (int k = 0; k < 3; k++) s_ra[k] = pick_addr();
      drive((n % 100 == 0) ? $sformatf("random batch %0d", n / 100) : "");
      tick();
    end
    idle();
    drive("final probe");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
